// File: rtl/pixel_pkg.sv
// pixel_pkg: shared packing constants and the FIFO word layout for the RGB stream packer.
package pixel_pkg;
  localparam int BYTES_PER_PIXEL = 3;
  localparam int WORD_BYTES = 4;
  localparam int PIXELS_PER_GROUP = 4;
  localparam logic [3:0] KEEP_FULL = 4'hF;
  localparam logic [3:0] KEEP_3 = 4'h7;
  localparam logic [3:0] KEEP_2 = 4'h3;
  localparam logic [3:0] KEEP_1 = 4'h1;
  typedef logic [$clog2(PIXELS_PER_GROUP)-1:0] phase_t;
  typedef logic [8*BYTES_PER_PIXEL-1:0] pixel_t;
  typedef struct packed {
    logic tuser;
    logic tlast;
    logic [WORD_BYTES-1:0] tkeep;
    logic [8*WORD_BYTES-1:0] tdata;
  } word_t;
endpackage

// File: rtl/stream_word_fifo.sv
// stream_word_fifo: first-word-fall-through FIFO with two push ports (push1 implies push0) and one pop port.
module stream_word_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push0_i,
  input  logic                   push1_i,
  input  word_t                  din0_i,
  input  word_t                  din1_i,
  input  logic                   pop_i,
  output word_t                  dout_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  word_t mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  always_comb begin
    valid_o = cnt_q != '0;
    do_pop = pop_i && valid_o;
    dout_o = valid_o ? mem[rd_q] : '0;
    count_o = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (push0_i) mem[wr_q] <= din0_i;
    if (push1_i) mem[wr_q + AW'(1)] <= din1_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push0_i) + AW'(push1_i);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(push0_i) + CW'(push1_i) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer: packs RGB888 pixels four-into-three 32-bit AXI4-Stream words with tuser/tlast/tkeep.
module rgb_stream_packer
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        out_stream_tuser,
  output logic        sync_err
);
  localparam int FIFO_AWIDTH = $clog2(FIFO_DEPTH);
  localparam int CW = FIFO_AWIDTH + 1;
  phase_t phase_q, phase_d, ph;
  pixel_t stage_q, stage_d, px;
  logic tu_pend_q, tu_pend_d, err_q, err_d, rdy_q, rdy_d;
  logic acc, tu, push0, push1, pop;
  word_t w0, w1, head;
  logic [CW-1:0] fifo_cnt, cnt_nx;
  // a sof pixel always restarts the group, so it is packed as if the phase were 0
  always_comb begin
    acc = valid && rdy_q;
    ph = sof ? phase_t'(0) : phase_q;
    tu = sof || tu_pend_q;
    px = {r, g, b};
    push0 = acc && (ph != 2'd0 || eol);
    push1 = acc && eol && (ph == 2'd1 || ph == 2'd2);
    w0.tdata = ph == 2'd0 ? {8'h00, px} :
               ph == 2'd1 ? {px[7:0], stage_q} :
               ph == 2'd2 ? {px[15:0], stage_q[15:0]} : {px, stage_q[7:0]};
    w0.tkeep = ph == 2'd0 ? KEEP_3 : KEEP_FULL;
    w0.tlast = eol && (ph == 2'd0 || ph == 2'd3);
    w0.tuser = tu;
    w1.tdata = ph == 2'd1 ? {16'h0000, px[23:8]} : {24'h000000, px[23:16]};
    w1.tkeep = ph == 2'd1 ? KEEP_2 : KEEP_1;
    w1.tlast = 1'b1;
    w1.tuser = 1'b0;
    phase_d = !acc ? phase_q : eol ? phase_t'(0) : ph + phase_t'(1);
    stage_d = !acc ? stage_q :
              eol ? '0 :
              ph == 2'd0 ? px :
              ph == 2'd1 ? {8'h00, px[23:8]} :
              ph == 2'd2 ? {16'h0000, px[23:16]} : '0;
    tu_pend_d = acc ? (ph == 2'd0 && !eol && tu) : tu_pend_q;
    err_d = err_q || (acc && sof && phase_q != 2'd0);
    pop = out_stream_tvalid && out_stream_tready;
    cnt_nx = fifo_cnt + CW'(push0) + CW'(push1) - CW'(pop);
    rdy_d = cnt_nx <= CW'(FIFO_DEPTH - 2);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q <= '0;
      stage_q <= '0;
      tu_pend_q <= 1'b0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      stage_q <= stage_d;
      tu_pend_q <= tu_pend_d;
      err_q <= err_d;
      rdy_q <= rdy_d;
    end
  end
  stream_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (aclk),
    .rst_n  (aresetn),
    .push0_i(push0),
    .push1_i(push1),
    .din0_i (w0),
    .din1_i (w1),
    .pop_i  (out_stream_tready),
    .dout_o (head),
    .valid_o(out_stream_tvalid),
    .count_o(fifo_cnt)
  );
  always_comb begin
    out_stream_tdata = head.tdata;
    out_stream_tkeep = head.tkeep;
    out_stream_tlast = head.tlast;
    out_stream_tuser = head.tuser;
    in_stream_ready = rdy_q;
    sync_err = err_q;
  end
endmodule

// File: tb/tb_rgb_stream_packer.sv
// tb_rgb_stream_packer: byte-queue reference model checked every cycle, plus hand-computed word literals.
module tb_rgb_stream_packer;
  localparam int DEPTH = 4;
  logic aclk = 0, aresetn = 0;
  logic [7:0] r = 0, g = 0, b = 0;
  logic valid = 0, sof = 0, eol = 0, out_stream_tready = 0;
  logic in_stream_ready, out_stream_tlast, out_stream_tvalid, out_stream_tuser, sync_err;
  logic [31:0] out_stream_tdata;
  logic [3:0] out_stream_tkeep;
  logic [37:0] cur, prev;
  logic [37:0] mq[$], mlog[$], dlog[$];
  logic [7:0] pend[$];
  int checks = 0, errors = 0, mode = 0;
  bit armed = 0, stalled = 0, usr = 0, exp_err = 0;

  rgb_stream_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .r(r), .g(g), .b(b), .valid(valid), .sof(sof), .eol(eol),
    .in_stream_ready(in_stream_ready), .out_stream_tdata(out_stream_tdata),
    .out_stream_tkeep(out_stream_tkeep), .out_stream_tlast(out_stream_tlast),
    .out_stream_tvalid(out_stream_tvalid), .out_stream_tready(out_stream_tready),
    .out_stream_tuser(out_stream_tuser), .sync_err(sync_err)
  );

  always #5 aclk = ~aclk;
  assign cur = {out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata};

  // mode 0: always ready, 1: stalled, 2: random backpressure
  always @(posedge aclk) begin
    #2;
    out_stream_tready = mode == 1 ? 1'b0 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [37:0] wd(input bit u, input bit l, input logic [3:0] k, input logic [31:0] d);
    return {u, l, k, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic emit(input logic [37:0] w);
    mq.push_back(w);
    mlog.push_back(w);
  endtask

  // pixels become a byte stream b,g,r; every 4 bytes form a word, eol flushes the remainder
  task automatic model_px(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                          input logic s, input logic e);
    logic [31:0] d;
    int n;
    if (s) begin
      if (pend.size() != 0) exp_err = 1;
      pend.delete();
      usr = 1;
    end
    pend.push_back(bb);
    pend.push_back(gg);
    pend.push_back(rr);
    while (pend.size() >= 4) begin
      d = {pend[3], pend[2], pend[1], pend[0]};
      repeat (4) void'(pend.pop_front());
      emit(wd(usr, e && pend.size() == 0, 4'hF, d));
      usr = 0;
    end
    if (e && pend.size() != 0) begin
      n = pend.size();
      d = '0;
      for (int i = 0; i < n; i++) d[8*i +: 8] = pend[i];
      emit(wd(usr, 1'b1, 4'((1 << n) - 1), d));
      usr = 0;
      pend.delete();
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_tvalid", out_stream_tvalid, 0);
      chk("rst_ready", in_stream_ready, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_word", cur, 0);
      mq.delete();
      pend.delete();
      usr = 0;
      exp_err = 0;
      armed = 0;
      stalled = 0;
    end else begin
      chk("ready", in_stream_ready, armed && (DEPTH - mq.size() >= 2));
      chk("tvalid", out_stream_tvalid, mq.size() != 0);
      chk("sync_err", sync_err, exp_err);
      if (out_stream_tvalid && mq.size() != 0) chk("word", cur, mq[0]);
      if (stalled) chk("stable", cur, prev);
      stalled = out_stream_tvalid && !out_stream_tready;
      prev = cur;
      if (out_stream_tvalid && out_stream_tready) begin
        dlog.push_back(cur);
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (valid && in_stream_ready) model_px(r, g, b, sof, eol);
      armed = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input logic s, input logic e);
    bit ok = 0;
    int t = 0;
    r = rr; g = gg; b = bb; sof = s; eol = e; valid = 1;
    while (!ok && t < 300) begin
      @(negedge aclk);
      ok = in_stream_ready;
      @(posedge aclk);
      #1;
      t++;
    end
    valid = 0; sof = 0; eol = 0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pixel not accepted within %0d cycles", t);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((mq.size() != 0 || out_stream_tvalid) && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    chk("drain_empty", {mq.size() != 0, out_stream_tvalid}, 0);
    idle(1);
  endtask

  task automatic send_t1(input logic s);
    send(8'h01, 8'h02, 8'h03, s, 0);
    send(8'h11, 8'h12, 8'h13, 0, 0);
    send(8'h21, 8'h22, 8'h23, 0, 0);
    send(8'h31, 8'h32, 8'h33, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, nk;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_tvalid", out_stream_tvalid, 0);
    chk("reset_tdata", out_stream_tdata, 0);
    chk("reset_tkeep", out_stream_tkeep, 0);
    chk("reset_tlast", out_stream_tlast, 0);
    chk("reset_tuser", out_stream_tuser, 0);
    chk("reset_ready", in_stream_ready, 0);
    chk("reset_sync_err", sync_err, 0);
    aresetn = 1;
    mode = 0;
    idle(1);
    chk("ready_first_edge", in_stream_ready, 1);

    dlog.delete();
    send_t1(1);
    drain();
    chk("t1_count", dlog.size(), 3);
    chk("t1_w0", dlog[0], wd(1, 0, 4'hF, 32'h13010203));
    chk("t1_w1", dlog[1], wd(0, 0, 4'hF, 32'h22231112));
    chk("t1_w2", dlog[2], wd(0, 0, 4'hF, 32'h31323321));

    dlog.delete();
    for (int k = 0; k < 640; k++) send(8'(k), 8'(k >> 8), 8'h5A, k == 0, k == 639);
    drain();
    nl = 0;
    nk = 0;
    foreach (dlog[i]) begin
      if (dlog[i][36]) nl++;
      if (dlog[i][35:32] != 4'hF) nk++;
    end
    chk("line640_count", dlog.size(), 480);
    chk("line640_tlast_count", nl, 1);
    chk("line640_last_tlast", dlog[479][36], 1);
    chk("line640_partial_words", nk, 0);

    dlog.delete();
    mlog.delete();
    for (int k = 0; k < 6; k++) send(8'hA0 + 8'(k), 8'hB0 + 8'(k), 8'hC0 + 8'(k), k == 0, k == 5);
    send(8'h01, 8'h02, 8'h03, 0, 0);
    send(8'h11, 8'h12, 8'h13, 0, 0);
    send(8'h21, 8'h22, 8'h23, 0, 0);
    send(8'h31, 8'h32, 8'h33, 0, 1);
    drain();
    chk("model_flush_word", mlog[4], wd(0, 1, 4'h3, 32'h0000A5B5));
    chk("model_full_word", mlog[3], wd(0, 0, 4'hF, 32'hC5A4B4C4));
    chk("flush_count", dlog.size(), 8);
    chk("flush_w0", dlog[0], wd(1, 0, 4'hF, 32'hC1A0B0C0));
    chk("flush_w3", dlog[3], wd(0, 0, 4'hF, 32'hC5A4B4C4));
    chk("flush_partial", dlog[4], wd(0, 1, 4'h3, 32'h0000A5B5));
    chk("next_line_w0", dlog[5], wd(0, 0, 4'hF, 32'h13010203));
    chk("next_line_w2", dlog[7], wd(0, 1, 4'hF, 32'h31323321));

    dlog.delete();
    send(8'hAA, 8'hBB, 8'hCC, 1, 1);
    drain();
    chk("one_pixel_line", dlog[0], wd(1, 1, 4'h7, 32'h00AABBCC));

    dlog.delete();
    mode = 1;
    idle(1);
    fork
      for (int k = 0; k < 8; k++) send(8'(k), 8'h40 + 8'(k), 8'h80 + 8'(k), k == 0, k == 7);
      begin
        repeat (25) @(posedge aclk);
        #3;
        chk("stall_ready_low", in_stream_ready, 0);
        chk("stall_tvalid", out_stream_tvalid, 1);
        chk("stall_head", cur, wd(1, 0, 4'hF, 32'h81004080));
        mode = 0;
      end
    join
    drain();
    chk("stall_count", dlog.size(), 6);

    dlog.delete();
    send(8'h10, 8'h11, 8'h12, 1, 0);
    send(8'h20, 8'h21, 8'h22, 0, 0);
    send(8'h30, 8'h31, 8'h32, 1, 0);
    send(8'h40, 8'h41, 8'h42, 0, 0);
    send(8'h50, 8'h51, 8'h52, 0, 0);
    send(8'h60, 8'h61, 8'h62, 0, 1);
    drain();
    chk("resync_err", sync_err, 1);
    chk("resync_count", dlog.size(), 4);
    chk("resync_w0", dlog[0], wd(1, 0, 4'hF, 32'h22101112));
    chk("resync_new_group", dlog[1], wd(1, 0, 4'hF, 32'h42303132));
    chk("resync_last", dlog[3], wd(0, 1, 4'hF, 32'h60616250));
    send(8'h01, 8'h02, 8'h03, 1, 1);
    drain();
    chk("sync_err_sticky", sync_err, 1);

    dlog.delete();
    mode = 1;
    idle(1);
    send_t1(1);
    idle(2);
    chk("pre_reset_tvalid", out_stream_tvalid, 1);
    #2;
    aresetn = 0;
    #1;
    chk("async_rst_tvalid", out_stream_tvalid, 0);
    chk("async_rst_ready", in_stream_ready, 0);
    chk("async_rst_tdata", out_stream_tdata, 0);
    @(negedge aclk);
    @(negedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1;
    mode = 0;
    send_t1(1);
    drain();
    chk("post_reset_count", dlog.size(), 3);
    chk("post_reset_w0", dlog[0], wd(1, 0, 4'hF, 32'h13010203));
    chk("post_reset_sync_err", sync_err, 0);

    mode = 2;
    for (int f = 0; f < 2; f++) begin
      int w;
      w = f == 0 ? 32 : 30;
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < w; x++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(8'($urandom), 8'($urandom), 8'($urandom), x == 0 && y == 0, x == w - 1);
        end
    end
    mode = 0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
